pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 113 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Pipeline hazard controller for load-use, branch, mul/div stall
//               and halt, with a saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int unsigned MD_LAT = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load_depen,
    input  logic             br_taken,
    input  logic             md_start,
    input  logic             halt_req,
    input  logic             cnt_clr,
    output logic             wpcir,
    output logic             id_bubble,
    output logic             if_flush,
    output logic             ex_hold,
    output logic             md_done,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MDWAIT = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    // The md_start cycle itself is the first stall, so MDWAIT lasts MD_LAT-1 cycles.
    localparam logic [7:0] C_MD_LOAD = 8'(MD_LAT - 2);

    state_t           r_state;
    state_t           w_next_state;
    logic [7:0]       r_md_cnt;
    logic [7:0]       w_next_md_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    always_comb begin
        wpcir         = 1'b1;
        id_bubble     = 1'b0;
        if_flush      = 1'b0;
        ex_hold       = 1'b0;
        md_done       = 1'b0;
        w_next_state  = ST_RUN;
        w_next_md_cnt = r_md_cnt;
        case (r_state)
            ST_RUN: begin
                if (md_start) begin
                    wpcir   = 1'b0;
                    ex_hold = 1'b1;
                end else if (load_depen) begin
                    wpcir     = 1'b0;
                    id_bubble = 1'b1;
                end else if (br_taken) begin
                    if_flush = 1'b1;
                end
                if (md_start) begin
                    w_next_state  = ST_MDWAIT;
                    w_next_md_cnt = C_MD_LOAD;
                end else if (halt_req) begin
                    w_next_state = ST_HALT;
                end
            end
            ST_MDWAIT: begin
                wpcir   = 1'b0;
                ex_hold = 1'b1;
                if (r_md_cnt == 8'd0) begin
                    md_done      = 1'b1;
                    w_next_state = halt_req ? ST_HALT : ST_RUN;
                end else begin
                    w_next_state  = ST_MDWAIT;
                    w_next_md_cnt = r_md_cnt - 8'd1;
                end
            end
            ST_HALT: begin
                wpcir        = 1'b0;
                ex_hold      = 1'b1;
                w_next_state = halt_req ? ST_HALT : ST_RUN;
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state  <= ST_RUN;
            r_md_cnt <= 8'd0;
        end else begin
            r_state  <= w_next_state;
            r_md_cnt <= w_next_md_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (clr || cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (!wpcir && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign state     = r_state;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// Directed testbench for pipe_hazard_ctrl; a CNT_W=4 copy shares the stimulus
// to exercise counter saturation.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        clr;
    logic        load_depen;
    logic        br_taken;
    logic        md_start;
    logic        halt_req;
    logic        cnt_clr;
    logic        wpcir;
    logic        id_bubble;
    logic        if_flush;
    logic        ex_hold;
    logic        md_done;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic        wpcir4;
    logic        id_bubble4;
    logic        if_flush4;
    logic        ex_hold4;
    logic        md_done4;
    logic [1:0]  state4;
    logic [3:0]  stall_cnt4;

    int n_checks;
    int n_pass;

    pipe_hazard_ctrl #(.MD_LAT(8), .CNT_W(16)) u_dut (
        .clk(clk), .clr(clr), .load_depen(load_depen), .br_taken(br_taken),
        .md_start(md_start), .halt_req(halt_req), .cnt_clr(cnt_clr),
        .wpcir(wpcir), .id_bubble(id_bubble), .if_flush(if_flush),
        .ex_hold(ex_hold), .md_done(md_done), .state(state), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.MD_LAT(8), .CNT_W(4)) u_dut4 (
        .clk(clk), .clr(clr), .load_depen(load_depen), .br_taken(br_taken),
        .md_start(md_start), .halt_req(halt_req), .cnt_clr(cnt_clr),
        .wpcir(wpcir4), .id_bubble(id_bubble4), .if_flush(if_flush4),
        .ex_hold(ex_hold4), .md_done(md_done4), .state(state4), .stall_cnt(stall_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Apply inputs just after a rising edge and let combinational outputs settle.
    task automatic drive(input logic ld, input logic br, input logic md,
                         input logic hr, input logic cc, input logic rs);
        load_depen = ld;
        br_taken   = br;
        md_start   = md;
        halt_req   = hr;
        cnt_clr    = cc;
        clr        = rs;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctl(input string tag, input logic wp, input logic bub,
                             input logic fl, input logic eh, input logic dn,
                             input logic [1:0] st);
        check({tag, ".wpcir"},     32'(wpcir),     32'(wp));
        check({tag, ".id_bubble"}, 32'(id_bubble), 32'(bub));
        check({tag, ".if_flush"},  32'(if_flush),  32'(fl));
        check({tag, ".ex_hold"},   32'(ex_hold),   32'(eh));
        check({tag, ".md_done"},   32'(md_done),   32'(dn));
        check({tag, ".state"},     32'(state),     32'(st));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        clr = 1'b1; load_depen = 1'b0; br_taken = 1'b0;
        md_start = 1'b0; halt_req = 1'b0; cnt_clr = 1'b0;

        // Reset
        tick();
        drive(0, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check_ctl("reset", 1, 0, 0, 0, 0, 2'd0);
        check("reset.stall_cnt", 32'(stall_cnt), 32'd0);
        check("reset.stall_cnt4", 32'(stall_cnt4), 32'd0);

        // Load-use bubble for one cycle
        tick();
        drive(1, 0, 0, 0, 0, 0);
        check_ctl("ld", 0, 1, 0, 0, 0, 2'd0);
        check("ld.cnt_before", 32'(stall_cnt), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check_ctl("ld_after", 1, 0, 0, 0, 0, 2'd0);
        check("ld.cnt_after", 32'(stall_cnt), 32'd1);

        // Clear counter, then mul/div with every other hazard input asserted
        drive(0, 0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("cc.stall_cnt", 32'(stall_cnt), 32'd0);
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, (i == 0), 0, 0, 0);
            check_ctl($sformatf("md%0d", i), 0, 0, 0, 1, (i == 7), (i == 0) ? 2'd0 : 2'd1);
            check($sformatf("md%0d.stall_cnt", i), 32'(stall_cnt), 32'(i));
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        check_ctl("md_end", 1, 0, 0, 0, 0, 2'd0);
        check("md_end.stall_cnt", 32'(stall_cnt), 32'd8);

        // Load-use and branch together: no flush; branch alone next cycle flushes
        tick();
        drive(1, 1, 0, 0, 0, 0);
        check_ctl("ldbr", 0, 1, 0, 0, 0, 2'd0);
        tick();
        drive(0, 1, 0, 0, 0, 0);
        check_ctl("br", 1, 0, 1, 0, 0, 2'd0);

        // Halt requested in RUN takes effect the following cycle
        tick();
        drive(0, 0, 0, 1, 0, 0);
        check_ctl("hr_run", 1, 0, 0, 0, 0, 2'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check_ctl("hr_halt", 0, 0, 0, 1, 0, 2'd2);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check_ctl("hr_resume", 1, 0, 0, 0, 0, 2'd0);

        // Halt requested during MDWAIT: HALT after md_done, held 5 cycles
        tick();
        drive(0, 0, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 2; i < 8; i++) begin
            drive(0, 0, 0, 1, 0, 0);
            check($sformatf("mdh%0d.md_done", i), 32'(md_done), 32'(i == 7));
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 0, 0);
            check_ctl($sformatf("halt%0d", i), 0, 0, 0, 1, 0, 2'd2);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        check_ctl("halt_drop", 0, 0, 0, 1, 0, 2'd2);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check_ctl("halt_exit", 1, 0, 0, 0, 0, 2'd0);

        // Reset aborts MDWAIT in its third cycle
        tick();
        drive(0, 0, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        drive(0, 0, 0, 0, 0, 1);
        check("abort.state_before", 32'(state), 32'd1);
        check("abort.md_done_before", 32'(md_done), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check_ctl("abort", 1, 0, 0, 0, 0, 2'd0);
        check("abort.stall_cnt", 32'(stall_cnt), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("abort_quiet%0d.md_done", i), 32'(md_done), 32'd0);
        end

        // Saturation on the 4-bit copy, then clear
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 1, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("sat.state", 32'(state), 32'd0);
        check("sat.stall_cnt", 32'(stall_cnt), 32'd20);
        check("sat.stall_cnt4", 32'(stall_cnt4), 32'd15);
        drive(1, 0, 0, 0, 1, 0);
        check("cc_prio.wpcir", 32'(wpcir), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("cc_prio.stall_cnt", 32'(stall_cnt), 32'd0);
        check("cc_prio.stall_cnt4", 32'(stall_cnt4), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
